// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_lsu_pkg
// Desc     : Memop encodings, FSM state encodings and access decode helpers
// Revision : 1.0 - initial release
// ============================================================================
package mem_lsu_pkg;

    localparam logic [2:0] MEMOP_LB  = 3'b000;
    localparam logic [2:0] MEMOP_LH  = 3'b001;
    localparam logic [2:0] MEMOP_LW  = 3'b010;
    localparam logic [2:0] MEMOP_LBU = 3'b100;
    localparam logic [2:0] MEMOP_LHU = 3'b101;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_READ   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    function automatic logic is_legal(input logic [2:0] memop);
        is_legal = (memop == MEMOP_LB)  || (memop == MEMOP_LH)  ||
                   (memop == MEMOP_LW)  || (memop == MEMOP_LBU) ||
                   (memop == MEMOP_LHU);
    endfunction

    function automatic logic is_aligned(input logic [2:0] memop, input logic [1:0] addr_lo);
        case (memop)
            MEMOP_LH, MEMOP_LHU: is_aligned = ~addr_lo[0];
            MEMOP_LW:            is_aligned = (addr_lo == 2'b00);
            default:             is_aligned = 1'b1;
        endcase
    endfunction

    // Misaligned halfwords and words are broken into one byte beat per byte.
    function automatic logic [2:0] beat_count(input logic [2:0] memop, input logic aligned);
        if (aligned)
            beat_count = 3'd1;
        else if (memop == MEMOP_LW)
            beat_count = 3'd4;
        else
            beat_count = 3'd2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu_align
// Desc     : Combinational decode of legality, alignment, beat count and the
//            final extension of a byte-assembled load result
// Revision : 1.0 - initial release
// ============================================================================
module mem_lsu_align (
    input  logic [2:0]  i_memop,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_asm,
    output logic        o_legal,
    output logic        o_aligned,
    output logic [2:0]  o_beats,
    output logic [31:0] o_ext
);
    import mem_lsu_pkg::*;

    always_comb begin
        o_legal   = is_legal(i_memop);
        o_aligned = is_aligned(i_memop, i_addr_lo);
        o_beats   = beat_count(i_memop, o_aligned);
        case (i_memop)
            MEMOP_LH:  o_ext = {{16{i_asm[15]}}, i_asm[15:0]};
            MEMOP_LHU: o_ext = {16'd0, i_asm[15:0]};
            default:   o_ext = i_asm;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu
// Desc     : Load/store unit in front of the data-memory wrapper; splits
//            misaligned half/word accesses into byte beats
// Revision : 1.0 - initial release
// ============================================================================
module mem_lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_memop,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_datain,
    output logic [2:0]  mem_memop,
    output logic        mem_we,
    input  logic [31:0] mem_dataout
);
    import mem_lsu_pkg::*;

    logic [1:0]  r_state;
    logic [31:0] r_addr;
    logic [2:0]  r_memop;
    logic        r_we;
    logic [31:0] r_wdata;
    logic [1:0]  r_beat;
    logic [31:0] r_asm;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [2:0]  w_memop_sel;
    logic [1:0]  w_addr_lo_sel;
    logic        w_legal;
    logic        w_aligned;
    logic [2:0]  w_beats;
    logic [31:0] w_ext;
    logic [31:0] w_asm_next;
    logic        w_last;
    logic        w_active;

    // In IDLE the decoder looks at the incoming request, otherwise at the held one.
    assign w_memop_sel   = (r_state == ST_IDLE) ? req_memop     : r_memop;
    assign w_addr_lo_sel = (r_state == ST_IDLE) ? req_addr[1:0] : r_addr[1:0];

    mem_lsu_align u_align (
        .i_memop   (w_memop_sel),
        .i_addr_lo (w_addr_lo_sel),
        .i_asm     (w_asm_next),
        .o_legal   (w_legal),
        .o_aligned (w_aligned),
        .o_beats   (w_beats),
        .o_ext     (w_ext)
    );

    assign w_last   = ({1'b0, r_beat} == (w_beats - 3'd1));
    assign w_active = (r_state == ST_ACCESS) || (r_state == ST_READ);

    always_comb begin
        w_asm_next = r_asm;
        w_asm_next[{r_beat, 3'b000} +: 8] = mem_dataout[7:0];
    end

    always_comb begin
        mem_addr   = 32'd0;
        mem_datain = 32'd0;
        mem_memop  = 3'd0;
        if (w_active) begin
            mem_addr = r_addr + {30'd0, r_beat};
            if (w_aligned) begin
                mem_memop  = r_memop;
                mem_datain = r_wdata;
            end else begin
                mem_memop  = r_we ? MEMOP_LB : MEMOP_LBU;
                mem_datain = r_wdata >> {r_beat, 3'b000};
            end
        end
    end

    // Decoded from state so an asynchronous reset drops the write strobe at once.
    assign mem_we     = (r_state == ST_ACCESS) && r_we;
    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= 32'd0;
            r_memop <= 3'd0;
            r_we    <= 1'b0;
            r_wdata <= 32'd0;
            r_beat  <= 2'd0;
            r_asm   <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_memop <= req_memop;
                        r_we    <= req_we;
                        r_wdata <= req_wdata;
                        r_beat  <= 2'd0;
                        r_asm   <= 32'd0;
                        r_rdata <= 32'd0;
                        r_err   <= ~w_legal;
                        r_state <= w_legal ? ST_ACCESS : ST_RESP;
                    end
                end
                ST_ACCESS: begin
                    if (!r_we) begin
                        r_state <= ST_READ;
                    end else if (w_last) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_beat <= r_beat + 2'd1;
                    end
                end
                ST_READ: begin
                    r_asm <= w_asm_next;
                    if (w_aligned) begin
                        r_rdata <= mem_dataout;
                        r_state <= ST_RESP;
                    end else if (w_last) begin
                        r_rdata <= w_ext;
                        r_state <= ST_RESP;
                    end else begin
                        r_beat  <= r_beat + 2'd1;
                        r_state <= ST_ACCESS;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit sitting directly upstream of the data-memory wrapper (`dram`): accepts one CPU memory request at a time over a valid/ready handshake, drives the wrapper's `addr`/`datain`/`memop`/`we` port, and returns load data or store completion. Naturally aligned accesses pass through as a single beat. Misaligned halfword/word accesses, which the wrapper's byte-enable logic cannot express, are split into sequential byte beats, with load bytes reassembled little-endian and extended per the original memop.

## Interface
- No parameters; 32-bit address/data, 3-bit memop: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; 011/110/111 illegal.
- Clock and reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low. Memory `rdclk` and `wrclk` are both tied to `clk`.
- `clk` in 1: clock; `rst_n` in 1: async active-low reset.
- `req_valid` in 1: request present; `req_ready` out 1: request accepted when both high.
- `req_addr` in 32: byte address; `req_memop` in 3: access type; `req_we` in 1: 1 = store.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle pulse, request complete; no backpressure.
- `resp_rdata` out 32: load result, valid with `resp_valid`; 0 for stores and errors.
- `resp_err` out 1: illegal memop, valid with `resp_valid`.
- `mem_addr` out 32, `mem_datain` out 32, `mem_memop` out 3, `mem_we` out 1: to the wrapper.
- `mem_dataout` in 32: wrapper read data, valid the cycle after the address is clocked.

## Operation
- States: IDLE, ACCESS, READ, RESP.
- IDLE: `req_ready`=1. On accept, register addr/memop/we/wdata, clear beat counter and byte assembly register.
  - Illegal memop: go to RESP with err=1 and no memory beat.
  - Otherwise go to ACCESS.
- Aligned: byte at any address; halfword with addr[0]=0; word with addr[1:0]=00. Aligned accesses use one beat: `mem_addr`=addr, `mem_memop`=memop, `mem_datain`=wdata. Load result = `mem_dataout` unmodified.
- Misaligned: N=2 (half) or N=4 (word) byte beats, beat i at addr+i with 32-bit wrap.
  - Stores: `mem_memop`=000, `mem_datain`=wdata>>(8i).
  - Loads: `mem_memop`=100, byte i stored in assembly bits [8i+7:8i].
  - Final result: sign-extend from bit 15 for lh; zero-extend for lhu; full 32 bits for lw.
- ACCESS: address and data driven from registers.
  - Store: `mem_we`=1. After the edge, go to the next beat (stay in ACCESS) or to RESP when the last beat is done.
  - Load: go to READ.
- READ: capture `mem_dataout`. Then go to ACCESS for the next beat, or to RESP after the last beat.
- RESP: `resp_valid`=1 for one cycle, then go to IDLE. `req_ready`=0 outside IDLE.
- `mem_we` is combinational from state, so it is never high outside ACCESS-with-store.
- Reset values: state IDLE, so `req_ready`=1. All other outputs and registers are 0: `resp_valid`, `resp_rdata`, `resp_err`, `mem_we`, `mem_addr`, `mem_datain`, `mem_memop`.
- Reset mid-operation: return to IDLE immediately and drop `mem_we` asynchronously. Bytes already written by a partial misaligned store remain written. No response is issued.

## Timing
- Accept at edge E0.
- Aligned store: written at E1, `resp_valid` in the cycle after E1 (2 cycles after accept).
- Aligned load: `resp_valid` 3 cycles after accept.
- Misaligned store: N+1 cycles; misaligned load: 2N+1 cycles (word load: 9).
- Illegal memop: `resp_valid` with `resp_err`=1 in the cycle after accept.
- Back-to-back: next accept no earlier than the cycle after RESP.

## Structure
- `mem_lsu_pkg`: memop encodings (`MEMOP_LB`…`MEMOP_LHU`), state enum, `is_aligned` and `beat_count` functions.
- One sub-module, `mem_lsu_align`: combinational helper that decodes legal/aligned/beat count and the final extension. The FSM, beat counter and assembly register live in `mem_lsu`.

## Test plan
Memory preloaded with [0x100]=0x44332211 and [0x104]=0x88776655.
- lw 0x100 -> `resp_rdata`=0x44332211 with `resp_valid` 3 cycles after accept; exactly one `mem_addr`=0x100 beat.
- lw 0x103 -> 0x77665544; beats at 0x103, 0x104, 0x105, 0x106 all with `mem_memop`=100; `resp_valid` 9 cycles after accept.
- sw 0x102 with data 0xAABBCCDD -> 4 byte writes; memory becomes [0x100]=0xCCDD2211 and [0x104]=0x8877AABB; `resp_valid` 5 cycles after accept.
- sh 0x101 with data 0xBEEF, then lh 0x101 -> 0xFFFFBEEF; lhu 0x101 -> 0x0000BEEF; aligned lh 0x106 -> 0xFFFF8877.
- Illegal memop 011 -> `resp_err`=1 and `resp_rdata`=0 in the next cycle; `mem_we` never asserted.
- sw 0x102 with `rst_n` dropped after 2 write beats -> outputs go to reset values immediately; only 0x102 and 0x103 are modified; `req_ready`=1 after release; next request serviced normally.
